bf16_dot_ctrl_44: RTL

- Sequencer that computes a BF16 dot product, sum(A[i]*B[i]) for i = 0..len-1.
- Operands come from two synchronous-read operand memories.
- Uses one external BF16 multiplier (valid_in/valid_out handshake) and one external BF16 adder (sub tied to 0).
- Handles fetch, multiply, dependent accumulate, timeout and completion signalling.
- Sits between the layer-level scheduler and the shared BF16Mul_44 / BF16AddSub_44 arithmetic units.

---
 rtl/bf16_dot_ctrl_44.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bf16_dot_ctrl_44.sv
// BF16 dot-product sequencer: walks two operand memories and feeds one shared multiplier and one
// shared adder, keeping a single element in flight because each add depends on the accumulator.
module bf16_dot_ctrl_44 #(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_44,
    input  logic              rst_44,
    input  logic              start_44,
    input  logic [LEN_W-1:0]  len_44,
    input  logic [ADDR_W-1:0] base_a_44,
    input  logic [ADDR_W-1:0] base_b_44,
    output logic              busy_44,
    output logic              done_44,
    output logic [15:0]       result_44,
    output logic              err_44,
    output logic              rd_en_44,
    output logic [ADDR_W-1:0] rd_addr_a_44,
    output logic [ADDR_W-1:0] rd_addr_b_44,
    input  logic [15:0]       rd_data_a_44,
    input  logic [15:0]       rd_data_b_44,
    output logic [15:0]       mul_a_44,
    output logic [15:0]       mul_b_44,
    output logic              mul_valid_in_44,
    input  logic [15:0]       mul_result_44,
    input  logic              mul_valid_out_44,
    output logic [15:0]       add_a_44,
    output logic [15:0]       add_b_44,
    output logic              add_valid_in_44,
    input  logic [15:0]       add_result_44,
    input  logic              add_valid_out_44
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StMulIssue,
        StMulWait,
        StAddIssue,
        StAddWait,
        StFin
    } state_e;

    state_e            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [15:0]       acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_elem;
    logic              timeout_hit;

    always_comb begin
        last_elem   = (idx_q == len_q - LEN_W'(1));
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // All outputs are registered; strobes are set on the edge that enters their state.
    always_ff @(posedge clk_44) begin
        if (rst_44) begin
            state_q         <= StIdle;
            len_q           <= '0;
            idx_q           <= '0;
            base_a_q        <= '0;
            base_b_q        <= '0;
            acc_q           <= '0;
            cnt_q           <= '0;
            busy_44         <= 1'b0;
            done_44         <= 1'b0;
            result_44       <= '0;
            err_44          <= 1'b0;
            rd_en_44        <= 1'b0;
            rd_addr_a_44    <= '0;
            rd_addr_b_44    <= '0;
            mul_a_44        <= '0;
            mul_b_44        <= '0;
            mul_valid_in_44 <= 1'b0;
            add_a_44        <= '0;
            add_b_44        <= '0;
            add_valid_in_44 <= 1'b0;
        end else begin
            done_44         <= 1'b0;
            rd_en_44        <= 1'b0;
            mul_valid_in_44 <= 1'b0;
            add_valid_in_44 <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_44) begin
                        len_q    <= len_44;
                        base_a_q <= base_a_44;
                        base_b_q <= base_b_44;
                        idx_q    <= '0;
                        acc_q    <= '0;
                        err_44   <= 1'b0;
                        busy_44  <= 1'b1;
                        if (len_44 == '0) begin
                            done_44   <= 1'b1;
                            result_44 <= '0;
                            state_q   <= StFin;
                        end else begin
                            rd_en_44     <= 1'b1;
                            rd_addr_a_44 <= base_a_44;
                            rd_addr_b_44 <= base_b_44;
                            state_q      <= StFetch;
                        end
                    end
                end
                StFetch: state_q <= StLatch;
                StLatch: begin
                    mul_a_44        <= rd_data_a_44;
                    mul_b_44        <= rd_data_b_44;
                    mul_valid_in_44 <= 1'b1;
                    state_q         <= StMulIssue;
                end
                StMulIssue: begin
                    cnt_q   <= '0;
                    state_q <= StMulWait;
                end
                StMulWait: begin
                    if (mul_valid_out_44) begin
                        // add_b_44 doubles as the product register.
                        add_a_44        <= acc_q;
                        add_b_44        <= mul_result_44;
                        add_valid_in_44 <= 1'b1;
                        state_q         <= StAddIssue;
                    end else if (timeout_hit) begin
                        err_44    <= 1'b1;
                        done_44   <= 1'b1;
                        result_44 <= acc_q;
                        state_q   <= StFin;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StAddIssue: begin
                    cnt_q   <= '0;
                    state_q <= StAddWait;
                end
                StAddWait: begin
                    if (add_valid_out_44) begin
                        acc_q <= add_result_44;
                        if (last_elem) begin
                            done_44   <= 1'b1;
                            result_44 <= add_result_44;
                            state_q   <= StFin;
                        end else begin
                            idx_q        <= idx_q + LEN_W'(1);
                            rd_en_44     <= 1'b1;
                            rd_addr_a_44 <= base_a_q + ADDR_W'(idx_q + LEN_W'(1));
                            rd_addr_b_44 <= base_b_q + ADDR_W'(idx_q + LEN_W'(1));
                            state_q      <= StFetch;
                        end
                    end else if (timeout_hit) begin
                        err_44    <= 1'b1;
                        done_44   <= 1'b1;
                        result_44 <= acc_q;
                        state_q   <= StFin;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StFin: begin
                    busy_44 <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
